// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } fetch_out_t;

    function automatic logic is_misaligned(input logic [63:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one bus request per PC and
// buffers the returned instruction toward decode, honouring redirects anywhere.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [63:0] next_pc,
    input  logic        redirect,
    output logic [63:0] pc,
    output logic [63:0] pc_plus4,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        ireq_ready,
    input  logic        iresp_valid,
    input  logic [31:0] iresp_data,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_misalign,
    input  logic        if_ready
);

    fetch_state_t state_r;
    logic [63:0]  pc_r;
    logic         discard_r;
    logic         if_valid_r;
    fetch_out_t   buf_r;
    logic         misalign_s;
    logic         req_s;

    assign misalign_s  = is_misaligned(pc_r);
    assign req_s       = (state_r == REQ) && !misalign_s;

    assign pc          = pc_r;
    assign pc_plus4    = pc_r + 64'd4;
    assign ireq_valid  = req_s;
    assign ireq_addr   = pc_r;
    assign if_valid    = if_valid_r;
    assign if_pc       = buf_r.pc;
    assign if_instr    = buf_r.instr;
    assign if_misalign = buf_r.misalign;

    // Fetch FSM, PC register, discard flag and decode buffer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= REQ;
            pc_r       <= RESET_PC;
            discard_r  <= 1'b0;
            if_valid_r <= 1'b0;
            buf_r      <= '0;
        end else begin
            case (state_r)
                REQ: begin
                    if (redirect) begin
                        pc_r <= next_pc;
                        // An accepted old request still returns data; mark it to be thrown away.
                        if (req_s && ireq_ready) begin
                            state_r   <= WAIT;
                            discard_r <= 1'b1;
                        end else begin
                            state_r <= REQ;
                        end
                    end else if (misalign_s) begin
                        buf_r      <= '{pc: pc_r, instr: 32'h0, misalign: 1'b1};
                        if_valid_r <= 1'b1;
                        state_r    <= HOLD;
                    end else if (ireq_ready) begin
                        state_r <= WAIT;
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        pc_r <= next_pc;
                        if (iresp_valid) begin
                            discard_r <= 1'b0;
                            state_r   <= REQ;
                        end else begin
                            discard_r <= 1'b1;
                            state_r   <= WAIT;
                        end
                    end else if (iresp_valid) begin
                        if (discard_r) begin
                            discard_r <= 1'b0;
                            state_r   <= REQ;
                        end else begin
                            buf_r      <= '{pc: pc_r, instr: iresp_data, misalign: 1'b0};
                            if_valid_r <= 1'b1;
                            state_r    <= HOLD;
                        end
                    end else begin
                        state_r <= WAIT;
                    end
                end
                HOLD: begin
                    if (redirect || if_ready) begin
                        pc_r       <= next_pc;
                        if_valid_r <= 1'b0;
                        state_r    <= REQ;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r    <= REQ;
                    discard_r  <= 1'b0;
                    if_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that owns the architectural PC register and sits directly downstream of the PC select mux. It drives `pc` and `pc_plus4` back into the mux, loads the mux output as the next PC, and issues one instruction-bus request per PC. It presents the returned 32-bit instruction with its PC to decode over a valid/ready handshake. It handles redirects (branch/jump/trap) in any state, including discarding a response already in flight.

## Interface
- `RESET_PC`, default 64'h0000_0000_8000_0000: PC value loaded at reset.
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `next_pc` in 64: selected next PC from the PC mux.
- `redirect` in 1: mux select is a non-sequential source this cycle; the PC must load `next_pc` immediately.
- `pc` out 64: current PC register, fed to the mux default input.
- `pc_plus4` out 64: `pc + 4`, modulo 2^64, fed to the mux sequential input.
- `ireq_valid` out 1: fetch request.
- `ireq_addr` out 64: request address, always equal to `pc`.
- `ireq_ready` in 1: request accepted this cycle.
- `iresp_valid` in 1: response data valid.
- `iresp_data` in 32: instruction word.
- `if_valid` out 1: instruction buffer valid toward decode.
- `if_pc` out 64: PC of the buffered instruction.
- `if_instr` out 32: buffered instruction.
- `if_misalign` out 1: buffered entry is an instruction-address-misaligned fault.
- `if_ready` in 1: decode accepts the buffer.

## Operation
- FSM states: REQ, WAIT, HOLD. A 1-bit `discard` flag tracks an abandoned in-flight request.
- Reset values: state=REQ, `pc`=RESET_PC, `discard`=0, `if_valid`=0, `if_pc`=0, `if_instr`=0, `if_misalign`=0.
- REQ behaviour:
  - If `pc[1:0]`≠0: `ireq_valid`=0; load the buffer with `if_pc`=pc, `if_instr`=0, `if_misalign`=1; go to HOLD.
  - Otherwise: `ireq_valid`=1; on `ireq_ready` go to WAIT.
- WAIT behaviour, `ireq_valid`=0; on `iresp_valid`:
  - If `discard`=1: clear it and go to REQ.
  - If `discard`=0: load the buffer with `if_pc`=pc, `if_instr`=iresp_data, `if_misalign`=0, set `if_valid`=1, go to HOLD.
- HOLD behaviour:
  - `if_valid`=1.
  - On `if_valid && if_ready`: `pc`←`next_pc`, `if_valid`←0, go to REQ.
  - Control drives the mux so that `next_pc` = `pc_plus4` for sequential flow.
- Redirect always wins. When `redirect`=1 in any state, `pc`←`next_pc` that edge, and:
  - REQ, no `ireq_ready`: stay in REQ; the address changes to the new PC next cycle, which is legal because the old request was never accepted.
  - REQ with `ireq_ready` the same cycle: go to WAIT with `discard`=1.
  - WAIT without `iresp_valid`: set `discard`=1 and stay in WAIT.
  - WAIT with `iresp_valid` the same cycle: drop the data and go to REQ; `discard` stays 0.
  - HOLD: `if_valid`←0, go to REQ. A simultaneous `if_ready` still counts as accepted; decode takes it, and control is responsible for the flush.
- Only one outstanding bus request at a time. `iresp_valid` outside WAIT is ignored.
- Reset asserted mid-operation returns all state to reset values immediately. Any response arriving after reset release while in REQ is ignored.

## Timing
- First `ireq_valid` appears in the first cycle after `resetn` deasserts.
- With zero-wait memory (ready in the same cycle as the request, response one cycle later):
  - request at cycle t, response at t+1, `if_valid` at t+2.
  - Decode handshake at t+2 gives the next request at t+3.
  - Steady throughput is one instruction per 3 cycles.
- Redirect at cycle t puts the new address on `ireq_addr` at t+1, unless state is WAIT with `discard`.
- `pc_plus4` is combinational from `pc`. All other outputs are registered or decoded from state and registers; there is no input→output combinational path except `ireq_addr` = `pc`.
- `pc_plus4` wraps: FFFF_FFFF_FFFF_FFFC + 4 = 0.

## Structure
- The shared package `fetch_pkg` holds:
  - `fetch_state_t` enum {REQ, WAIT, HOLD};
  - `RESET_PC_DEFAULT`;
  - a packed `fetch_out_t` struct {pc, instr, misalign}.
- No sub-module is needed. The PC mux is instantiated alongside this block at the stage level, not inside it.

## Test plan
- Reset release, memory returns 32'h0000_0013 one cycle after acceptance, `if_ready`=1 → `ireq_addr`=8000_0000, then `if_pc`=8000_0000 with that instr, then `ireq_addr`=8000_0004 three cycles after the first request.
- `if_ready`=0 for 5 cycles in HOLD → `if_valid`, `if_pc` and `if_instr` stay stable and no new `ireq_valid` is issued.
- Redirect to 8000_0100 while in WAIT, then response 32'hDEAD_BEEF → no `if_valid` for that data, next request at 8000_0100.
- Redirect in the same cycle as `iresp_valid` → data dropped, next cycle `ireq_addr`=new PC, `discard`=0.
- Redirect to 8000_0102 → no bus request, `if_valid`=1 with `if_misalign`=1, `if_pc`=8000_0102, `if_instr`=0.
- `resetn` pulsed low during WAIT → outputs return to reset values asynchronously, the fetch restarts at RESET_PC, and the late response is ignored.
